// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode, ALU control and FSM state encodings shared by the sequencer and its decoder
package alu_seq_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AND  = 4'h1;
  localparam logic [3:0] OP_OR   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_NOR  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_WB     = 2'd3
  } state_t;
endpackage

// File: rtl/alu_instr_decode.sv
// alu_instr_decode: opcode -> ALU control, operand select, nop/illegal flags and overflow-tracking enable
module alu_instr_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  output logic [3:0] ctl,
  output logic       sel,
  output logic       is_nop,
  output logic       is_illegal,
  output logic       ovf_check
);
  always_comb begin
    ctl = op == OP_OR ? CTL_OR :
          (op == OP_ADD || op == OP_ADDI) ? CTL_ADD :
          op == OP_SUB ? CTL_SUB :
          op == OP_SLT ? CTL_SLT :
          op == OP_NOR ? CTL_NOR : CTL_AND;
    sel = op == OP_ADDI;
    is_nop = op == OP_NOP;
    is_illegal = op[3];
    ovf_check = op == OP_ADD || op == OP_SUB || op == OP_ADDI;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts 16-bit instructions over valid/ready and sequences decode, ALU execute and register write-back
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [3:0]       ReadRgAddr1,
  output logic [3:0]       ReadRgAddr2,
  output logic [3:0]       WriteRgAddr,
  output logic [15:0]      immediate,
  output logic             sel,
  output logic [3:0]       Control,
  input  logic             Overflow,
  output logic             done,
  output logic             illegal,
  output logic             ovf_sticky,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] retired_count
);
  localparam int LW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  state_t st, nx;
  logic [15:0] iq;
  logic [LW-1:0] cnt;
  logic nop, ill, ovf_chk;
  alu_instr_decode u_dec (
    .op        (iq[15:12]),
    .ctl       (Control),
    .sel       (sel),
    .is_nop    (nop),
    .is_illegal(ill),
    .ovf_check (ovf_chk)
  );
  assign ReadRgAddr1 = iq[7:4];
  assign ReadRgAddr2 = iq[3:0];
  assign immediate = {12'b0, iq[3:0]};
  always_comb begin
    nx = st == S_IDLE ? (instr_valid && instr_ready ? S_DECODE : S_IDLE) :
         st == S_DECODE ? (nop || ill ? S_IDLE : S_EXEC) :
         st == S_EXEC ? (cnt == '0 ? S_WB : S_EXEC) : S_IDLE;
    instr_ready = st == S_IDLE && !rst;
    WriteRgAddr = st == S_WB ? iq[11:8] : 4'd0;
    done = st == S_WB || (st == S_DECODE && (nop || ill));
    illegal = st == S_DECODE && ill;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= S_IDLE;
      iq <= '0;
      cnt <= '0;
      ovf_sticky <= 1'b0;
      retired_count <= '0;
    end else begin
      st <= nx;
      if (instr_valid && instr_ready) iq <= instr;
      cnt <= st == S_EXEC ? cnt - LW'(1) : LW'(ALU_LAT - 1);
      ovf_sticky <= (st == S_WB && ovf_chk && Overflow) || (ovf_sticky && !ovf_clr);
      retired_count <= retired_count + CNT_W'(done && !illegal);
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: scoreboard bench with a behavioural instruction model, a register-file/ALU stand-in and directed plus random stimulus
module tb_alu_op_sequencer;
  localparam int LAT = 3;
  localparam int CW = 4;
  logic clk = 0, rst = 1, instr_valid = 0, Overflow = 0, ovf_clr = 0;
  logic [15:0] instr = '0;
  logic instr_ready, sel, done, illegal, ovf_sticky;
  logic [3:0] ReadRgAddr1, ReadRgAddr2, WriteRgAddr, Control;
  logic [15:0] immediate;
  logic [CW-1:0] retired_count;
  alu_op_sequencer #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ReadRgAddr1(ReadRgAddr1), .ReadRgAddr2(ReadRgAddr2), .WriteRgAddr(WriteRgAddr),
    .immediate(immediate), .sel(sel), .Control(Control), .Overflow(Overflow), .done(done),
    .illegal(illegal), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr), .retired_count(retired_count)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [15:0] rf [16] = '{default: 16'h0};
  logic [15:0] a, b, wd;
  always_comb begin
    a = rf[ReadRgAddr1];
    b = sel ? immediate : rf[ReadRgAddr2];
    wd = '0;
    case (Control)
      4'b0000: wd = a & b;
      4'b0001: wd = a | b;
      4'b0010: wd = a + b;
      4'b0110: wd = a - b;
      4'b0111: wd = {15'b0, $signed(a) < $signed(b)};
      4'b1100: wd = ~(a | b);
      default: wd = 16'hDEAD;
    endcase
  end
  always @(posedge clk) if (WriteRgAddr != 0) rf[WriteRgAddr] <= wd;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask
  typedef struct {
    logic [3:0] op, rd, rs, rt;
    logic ill, wchk;
    logic [15:0] wd;
    int acc, lat;
    logic [CW-1:0] rc;
    logic st;
  } exp_t;
  exp_t q[$];
  exp_t me;
  logic [15:0] mrf [16] = '{default: 16'h0};
  int m_rc = 0;
  bit m_st = 0;
  int last_done = -1;
  bit gapped = 1;
  logic [3:0] ctl_tab [8] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h2};
  function automatic logic [15:0] ref_val(input logic [3:0] op, input logic [15:0] x, y, input logic [3:0] imm);
    int sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    case (op)
      1: return x & y;
      2: return x | y;
      3: return x + y;
      4: return x - y;
      5: return sx < sy ? 16'd1 : 16'd0;
      6: return ~(x | y);
      7: return x + {12'd0, imm};
      default: return 16'd0;
    endcase
  endfunction
  task automatic issue(input logic [15:0] w, input bit ov, input bit clr, input int gap);
    exp_t e;
    int n;
    instr = w;
    instr_valid = 1;
    Overflow = ov;
    ovf_clr = clr;
    n = 0;
    do begin @(negedge clk); n++; end while (!instr_ready && n < 64);
    if (!instr_ready) begin timeout("accept"); return; end
    if (!gapped) chk("b2b_accept_cycle", cyc, last_done + 1);
    e.op = w[15:12]; e.rd = w[11:8]; e.rs = w[7:4]; e.rt = w[3:0];
    e.acc = cyc;
    e.ill = e.op >= 8;
    e.lat = (e.op == 0 || e.ill) ? 1 : 2 + LAT;
    e.wchk = !e.ill && e.op != 0 && e.rd != 0;
    e.wd = ref_val(e.op, mrf[e.rs], mrf[e.rt], e.rt);
    if (!e.ill) m_rc = (m_rc + 1) % (1 << CW);
    m_st = ((e.op == 3 || e.op == 4 || e.op == 7) && ov) ? 1'b1 : clr ? 1'b0 : m_st;
    e.rc = CW'(m_rc);
    e.st = m_st;
    if (e.wchk) mrf[e.rd] = e.wd;
    q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 64);
    if (!done) timeout("done");
    last_done = cyc;
    @(posedge clk);
    #1;
    gapped = gap > 0;
    if (gap > 0) begin
      instr_valid = 0;
      Overflow = 0;
      ovf_clr = 0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (!done) begin
        chk("wa_zero_when_idle", WriteRgAddr, 0);
        chk("illegal_without_done", illegal, 0);
      end else if (q.size() == 0) begin
        timeout("unexpected_done");
      end else begin
        me = q.pop_front();
        chk("latency", cyc - me.acc, me.lat);
        chk("illegal", illegal, me.ill);
        chk("ReadRgAddr1", ReadRgAddr1, me.rs);
        chk("ReadRgAddr2", ReadRgAddr2, me.rt);
        chk("immediate", immediate, {12'd0, me.rt});
        chk("WriteRgAddr", WriteRgAddr, (me.ill || me.op == 0) ? 4'd0 : me.rd);
        if (!me.ill && me.op != 0) begin
          chk("Control", Control, ctl_tab[me.op[2:0]]);
          chk("sel", sel, me.op == 7);
        end
        if (me.wchk) chk("write_data", wd, me.wd);
        @(negedge clk);
        chk("retired_count", retired_count, me.rc);
        chk("ovf_sticky", ovf_sticky, me.st);
      end
    end
  end
  logic [15:0] dir_w [10] = '{16'h7103, 16'h720F, 16'h3512, 16'h4612, 16'h5712,
                              16'h6812, 16'h1912, 16'hA123, 16'h0000, 16'h4A12};
  bit dir_ov [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 1};
  bit dir_clr [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
  initial begin
    logic [3:0] op;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", instr_ready, 0);
    chk("rst_WriteRgAddr", WriteRgAddr, 0);
    chk("rst_Control", Control, 0);
    chk("rst_done", done, 0);
    chk("rst_retired", retired_count, 0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) issue(dir_w[i], dir_ov[i], dir_clr[i], 0);
    chk("rf_r1", rf[1], 16'h0003);
    chk("rf_r2", rf[2], 16'h000F);
    chk("rf_r5", rf[5], 16'h0012);
    chk("rf_r6", rf[6], 16'hFFF4);
    chk("rf_r7", rf[7], 16'h0001);
    chk("rf_r8", rf[8], 16'hFFF0);
    for (int i = 0; i < 80; i++) begin
      op = ($urandom % 5 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      issue({op, 12'($urandom)}, 1'($urandom), $urandom % 4 == 0,
            ($urandom % 3 == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    instr = 16'h3312;
    instr_valid = 1;
    Overflow = 0;
    ovf_clr = 0;
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!instr_ready && n < 64);
      if (!instr_ready) timeout("reset_accept");
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1;
    instr_valid = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_instr_ready", instr_ready, 0);
    chk("midrst_WriteRgAddr", WriteRgAddr, 0);
    chk("midrst_ReadRgAddr1", ReadRgAddr1, 0);
    chk("midrst_ReadRgAddr2", ReadRgAddr2, 0);
    chk("midrst_immediate", immediate, 0);
    chk("midrst_sel", sel, 0);
    chk("midrst_Control", Control, 0);
    chk("midrst_done", done, 0);
    chk("midrst_illegal", illegal, 0);
    chk("midrst_sticky", ovf_sticky, 0);
    chk("midrst_retired", retired_count, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("postrst_instr_ready", instr_ready, 1);
    chk("midrst_no_write_r3", rf[3], mrf[3]);
    m_rc = 0;
    m_st = 0;
    gapped = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 9));
      issue({op, 12'($urandom)}, 1'($urandom), $urandom % 4 == 0, int'($urandom_range(0, 1)));
    end
    repeat (4) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
